// File: rtl/write_back_cache.sv
// Direct-mapped write-back, write-allocate data cache in front of a block memory.
// Define CACHE_STATS_EN to build the hit/miss statistics counters.
module write_back_cache #(
   parameter int LINE_SIZE = 16,
   parameter int NUM_SETS  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   is_input_valid,
   input  logic [31:0]            addr,
   input  logic                   mem_rw,
   input  logic [31:0]            din,
   output logic                   is_ready,
   output logic                   is_output_valid,
   output logic [31:0]            dout,
   output logic                   is_hit,
   output logic                   dmem_is_input_valid,
   output logic [31:0]            dmem_addr,
   output logic                   dmem_read,
   output logic                   dmem_write,
   output logic [LINE_SIZE*8-1:0] dmem_din,
   input  logic                   dmem_is_output_valid,
   input  logic [LINE_SIZE*8-1:0] dmem_dout,
   input  logic                   dmem_ready,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
);
   localparam int OFF_W  = $clog2(LINE_SIZE);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int TAG_W  = 32 - OFF_W - IDX_W;
   localparam int LINE_W = LINE_SIZE * 8;
   localparam int WORDS  = LINE_SIZE / 4;

   typedef enum logic [2:0] {
      IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT
   } state_t;

   state_t state, state_nx;
   logic   ready_seen_low;

   logic [LINE_W-1:0]   data_q [NUM_SETS];
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [NUM_SETS-1:0] valid_q;
   logic [NUM_SETS-1:0] dirty_q;

   logic [OFF_W-1:0]  off;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   logic [LINE_W-1:0] cur_line;
   logic [LINE_W-1:0] upd_line;
   logic [TAG_W-1:0]  cur_tag;
   logic [31:0]       cur_word;
   logic              lookup, hit, miss, victim_dirty;
   logic              wr_hit, fill_done, wb_done;

   assign off      = addr[OFF_W-1:0];
   assign idx      = addr[OFF_W +: IDX_W];
   assign tag      = addr[31 -: TAG_W];
   assign cur_line = data_q[idx];
   assign cur_tag  = tag_q[idx];

   assign lookup       = (state == IDLE) && is_input_valid;
   assign hit          = lookup && valid_q[idx] && (cur_tag == tag);
   assign miss         = lookup && !hit;
   assign wr_hit       = hit && mem_rw;
   assign victim_dirty = valid_q[idx] && dirty_q[idx];
   assign fill_done    = (state == FILL_WAIT) && dmem_is_output_valid;
   assign wb_done      = (state == WB_WAIT) && ready_seen_low && dmem_ready;

   always_comb begin
      cur_word = '0;
      upd_line = cur_line;
      for (int w = 0; w < WORDS; w++) begin
         if ((off >> 2) == OFF_W'(w)) begin
            cur_word = cur_line[w*32 +: 32];
            upd_line[w*32 +: 32] = din;
         end
      end
   end

   // The write-back completes only once the memory has gone busy and come back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         ready_seen_low <= 1'b0;
      end else begin
         state          <= state_nx;
         ready_seen_low <= (state == WB_WAIT) && (state_nx == WB_WAIT) &&
                           (ready_seen_low || !dmem_ready);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (miss)
               state_nx = victim_dirty ? WB_REQ : FILL_REQ;
         end
         WB_REQ: begin
            if (dmem_ready)
               state_nx = WB_WAIT;
         end
         WB_WAIT: begin
            if (wb_done)
               state_nx = FILL_REQ;
         end
         FILL_REQ: begin
            if (dmem_ready)
               state_nx = FILL_WAIT;
         end
         FILL_WAIT: begin
            if (dmem_is_output_valid)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      is_ready            = (state == IDLE);
      is_hit              = hit;
      is_output_valid     = hit;
      dout                = (hit && !mem_rw) ? cur_word : '0;
      dmem_is_input_valid = 1'b0;
      dmem_read           = 1'b0;
      dmem_write          = 1'b0;
      dmem_addr           = '0;
      dmem_din            = '0;
      unique case (state)
         WB_REQ: begin
            if (dmem_ready) begin
               dmem_is_input_valid = 1'b1;
               dmem_write          = 1'b1;
               dmem_addr           = {{OFF_W{1'b0}}, cur_tag, idx};
               dmem_din            = cur_line;
            end
         end
         FILL_REQ: begin
            if (dmem_ready) begin
               dmem_is_input_valid = 1'b1;
               dmem_read           = 1'b1;
               dmem_addr           = {{OFF_W{1'b0}}, tag, idx};
            end
         end
         default: ;
      endcase
   end

   // Line storage needs no reset: valid bits guard every use.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_done) begin
            data_q[idx] <= dmem_dout;
            tag_q[idx]  <= tag;
         end else if (wr_hit) begin
            data_q[idx] <= upd_line;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_done) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
         dirty_q[idx] <= 1'b1;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_write_back_cache.sv
// Bench for write_back_cache: vector table, scoreboard and a DELAY=1 block memory.
module tb_write_back_cache;
   localparam int DELAY = 1;
   localparam int NV    = 9;

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] din;
      logic [31:0] exp_dout;
      int          exp_cyc;
      int          n_wr;
      logic [31:0] wr_addr;
      int          n_rd;
      logic [31:0] rd_addr;
   } vec_t;

   typedef struct {
      logic [31:0] dout;
      int          cyc;
      bit          rd;
   } exp_t;

   typedef struct {
      bit           wr;
      logic [31:0]  a;
      logic [127:0] d;
   } req_t;

   logic         clk;
   logic         reset;
   logic         is_input_valid;
   logic [31:0]  addr;
   logic         mem_rw;
   logic [31:0]  din;
   logic         is_ready;
   logic         is_output_valid;
   logic [31:0]  dout;
   logic         is_hit;
   logic         dmem_is_input_valid;
   logic [31:0]  dmem_addr;
   logic         dmem_read;
   logic         dmem_write;
   logic [127:0] dmem_din;
   logic         dmem_is_output_valid = 1'b0;
   logic [127:0] dmem_dout = '0;
   logic         dmem_ready;
   logic [31:0]  hit_count;
   logic [31:0]  miss_count;

   int n_checks = 0;
   int n_pass   = 0;

   exp_t sb_q[$];
   req_t log_q[$];
   vec_t vt[NV];

   logic [127:0] mem [bit [31:0]];
   bit           busy     = 1'b0;
   bit           hold_off = 1'b0;
   bit           req_s    = 1'b0;
   bit           req_wr   = 1'b0;
   bit           rd_pend  = 1'b0;
   int           cnt      = 0;
   logic [31:0]  req_a    = '0;
   logic [31:0]  pend_a   = '0;
   logic [127:0] req_d    = '0;

   write_back_cache dut (
      .clk                  (clk),
      .reset                (reset),
      .is_input_valid       (is_input_valid),
      .addr                 (addr),
      .mem_rw               (mem_rw),
      .din                  (din),
      .is_ready             (is_ready),
      .is_output_valid      (is_output_valid),
      .dout                 (dout),
      .is_hit               (is_hit),
      .dmem_is_input_valid  (dmem_is_input_valid),
      .dmem_addr            (dmem_addr),
      .dmem_read            (dmem_read),
      .dmem_write           (dmem_write),
      .dmem_din             (dmem_din),
      .dmem_is_output_valid (dmem_is_output_valid),
      .dmem_dout            (dmem_dout),
      .dmem_ready           (dmem_ready),
      .hit_count            (hit_count),
      .miss_count           (miss_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [127:0] mem_get(input logic [31:0] b);
      logic [127:0] r;
      if (mem.exists(b))
         return mem[b];
      for (int w = 0; w < 4; w++)
         r[w*32 +: 32] = {b[23:0], 8'(w)};
      return r;
   endfunction

   // Block memory: one request at a time, busy for DELAY cycles, then ready.
   assign dmem_ready = !busy && !hold_off;

   always @(negedge clk) begin
      if (dmem_is_input_valid) begin
         chk("dmem_req_legal",
             128'({dmem_ready, dmem_read ^ dmem_write}), 128'(2'b11));
         log_q.push_back('{wr: dmem_write, a: dmem_addr, d: dmem_din});
         req_s  = 1'b1;
         req_wr = dmem_write;
         req_a  = dmem_addr;
         req_d  = dmem_din;
      end else begin
         chk("dmem_idle_zero",
             128'({dmem_read, dmem_write}) | 128'(dmem_addr) | dmem_din,
             128'(0));
      end
   end

   always @(posedge clk) begin
      #1;
      dmem_is_output_valid = 1'b0;
      dmem_dout = '0;
      if (busy) begin
         cnt = cnt - 1;
         if (cnt == 0) begin
            busy = 1'b0;
            if (rd_pend) begin
               dmem_is_output_valid = 1'b1;
               dmem_dout = mem_get(pend_a);
               rd_pend = 1'b0;
            end
         end
      end
      if (req_s) begin
         busy = 1'b1;
         cnt  = DELAY;
         if (req_wr)
            mem[req_a] = req_d;
         else begin
            rd_pend = 1'b1;
            pend_a  = req_a;
         end
         req_s = 1'b0;
      end
   end

   // Called just after a posedge; returns just after a later posedge.
   task automatic do_req(input vec_t v, input int hold);
      int   cyc;
      int   base;
      int   nnew;
      bit   done;
      exp_t e;
      base = log_q.size();
      sb_q.push_back('{dout: v.exp_dout, cyc: v.exp_cyc, rd: !v.rw});
      hold_off       = (hold > 0);
      addr           = v.addr;
      mem_rw         = v.rw;
      din            = v.din;
      is_input_valid = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 60) begin
         @(negedge clk);
         if (cyc >= 1 && cyc <= hold) begin
            chk("hold_no_req", 128'(dmem_is_input_valid), 128'(0));
            chk("hold_not_ready", 128'(is_ready), 128'(0));
         end
         if (is_output_valid)
            done = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == hold + 1)
               hold_off = 1'b0;
         end
      end
      hold_off = 1'b0;
      e = sb_q.pop_front();
      chk($sformatf("done@%h", v.addr), 128'(done), 128'(1));
      if (done) begin
         chk($sformatf("is_hit@%h", v.addr), 128'(is_hit), 128'(1));
         chk($sformatf("latency@%h", v.addr), 128'(cyc), 128'(e.cyc));
         if (e.rd)
            chk($sformatf("dout@%h", v.addr), 128'(dout), 128'(e.dout));
      end
      nnew = log_q.size() - base;
      chk($sformatf("traffic@%h", v.addr), 128'(nnew), 128'(v.n_wr + v.n_rd));
      if (v.n_wr > 0 && nnew > 0)
         chk($sformatf("wb_addr@%h", v.addr),
             128'({log_q[base].wr, log_q[base].a}), 128'({1'b1, v.wr_addr}));
      if (v.n_rd > 0 && nnew > 0)
         chk($sformatf("rd_addr@%h", v.addr),
             128'({log_q[$].wr, log_q[$].a}), 128'({1'b0, v.rd_addr}));
      @(posedge clk);
      #1;
      is_input_valid = 1'b0;
   endtask

   initial begin
      vt[0] = '{32'h100, 1'b0, 32'h0, 32'h44332211, 4, 0, 32'h0, 1, 32'h10};
      vt[1] = '{32'h104, 1'b1, 32'hDEADBEEF, 32'h0, 0, 0, 32'h0, 0, 32'h0};
      vt[2] = '{32'h104, 1'b0, 32'h0, 32'hDEADBEEF, 0, 0, 32'h0, 0, 32'h0};
      vt[3] = '{32'h904, 1'b0, 32'h0, 32'h00009001, 7, 1, 32'h10, 1, 32'h90};
      vt[4] = '{32'h104, 1'b0, 32'h0, 32'hDEADBEEF, 4, 0, 32'h0, 1, 32'h10};
      vt[5] = '{32'h2C8, 1'b0, 32'h0, 32'h00002C02, 4, 0, 32'h0, 1, 32'h2C};
      vt[6] = '{32'h2CC, 1'b1, 32'h12345678, 32'h0, 0, 0, 32'h0, 0, 32'h0};
      vt[7] = '{32'h2CC, 1'b0, 32'h0, 32'h12345678, 0, 0, 32'h0, 0, 32'h0};
      vt[8] = '{32'h3F0, 1'b0, 32'h0, 32'h00003F00, 4, 0, 32'h0, 1, 32'h3F};

      mem[32'h10] = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'h44332211};

      reset          = 1'b1;
      is_input_valid = 1'b1;
      addr           = 32'h100;
      mem_rw         = 1'b0;
      din            = '0;
      @(negedge clk);
      chk("rst_is_ready", 128'(is_ready), 128'(1));
      chk("rst_is_hit", 128'(is_hit), 128'(0));
      chk("rst_out_valid", 128'(is_output_valid), 128'(0));
      chk("rst_dout", 128'(dout), 128'(0));
      chk("rst_dmem_valid", 128'(dmem_is_input_valid), 128'(0));
      chk("rst_counters", 128'({hit_count, miss_count}), 128'(0));
      is_input_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++)
         do_req(vt[i], 0);

      chk("wb_line_0x10", mem_get(32'h10),
          {32'hCAFE0003, 32'hCAFE0002, 32'hDEADBEEF, 32'h44332211});
`ifdef CACHE_STATS_EN
      chk("hit_count", 128'(hit_count), 128'(9));
      chk("miss_count", 128'(miss_count), 128'(5));
`else
      chk("hit_count", 128'(hit_count), 128'(0));
      chk("miss_count", 128'(miss_count), 128'(0));
`endif

      // Dirty miss with the memory held busy for three WB_REQ cycles.
      do_req('{32'h0C8, 1'b1, 32'hA5A5A5A5, 32'h0, 10, 1, 32'h2C, 1, 32'h0C}, 3);
      chk("wb_line_0x2c", mem_get(32'h2C),
          {32'h12345678, 32'h00002C02, 32'h00002C01, 32'h00002C00});
      do_req('{32'h0C8, 1'b0, 32'h0, 32'hA5A5A5A5, 0, 0, 32'h0, 0, 32'h0}, 0);
      do_req('{32'h0C4, 1'b0, 32'h0, 32'h00000C01, 0, 0, 32'h0, 0, 32'h0}, 0);

      // Reset while the fill is outstanding.
      addr           = 32'h500;
      mem_rw         = 1'b0;
      is_input_valid = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("fill_wait_busy", 128'(is_ready), 128'(0));
      reset = 1'b1;
      #1;
      chk("rst_mid_ready", 128'(is_ready), 128'(1));
      chk("rst_mid_out_valid", 128'(is_output_valid), 128'(0));
      chk("rst_mid_dmem", 128'(dmem_is_input_valid), 128'(0));
      chk("rst_mid_counters", 128'({hit_count, miss_count}), 128'(0));
      is_input_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      do_req('{32'h500, 1'b0, 32'h0, 32'h00005000, 4, 0, 32'h0, 1, 32'h50}, 0);
      do_req('{32'h104, 1'b0, 32'h0, 32'hDEADBEEF, 4, 0, 32'h0, 1, 32'h10}, 0);
      do_req('{32'h2CC, 1'b0, 32'h0, 32'h12345678, 4, 0, 32'h0, 1, 32'h2C}, 0);

      chk("scoreboard_empty", 128'(sb_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
